// File: rtl/viterbi_stream_tagger.sv
// Streaming min-sum Viterbi POS tagger: word IDs in, best tag sequence out in sentence order.
// Cost tables are external and read combinationally through registered address ports.
module viterbi_stream_tagger #(
   parameter int unsigned WORD_BITS = 4,
   parameter int unsigned TAG_NUM   = 11,
   parameter int unsigned TAG_BITS  = 4,
   parameter int unsigned P_SIZE    = 32,
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned LEN_BITS  = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 word_valid,
   output logic                 word_ready,
   input  logic [WORD_BITS-1:0] word,
   input  logic                 word_last,
   output logic [TAG_BITS-1:0]  trans_from,
   output logic [TAG_BITS-1:0]  trans_to,
   input  logic [P_SIZE-1:0]    trans_data,
   output logic [WORD_BITS-1:0] emiss_word,
   output logic [TAG_BITS-1:0]  emiss_tag,
   input  logic [P_SIZE-1:0]    emiss_data,
   output logic                 tag_valid,
   input  logic                 tag_ready,
   output logic [TAG_BITS-1:0]  tag,
   output logic [LEN_BITS-1:0]  tag_idx,
   output logic                 tag_last,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam int unsigned TI_BITS = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1;
   localparam int unsigned IX_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [TAG_BITS-1:0] LAST_TAG  = TAG_BITS'(TAG_NUM - 1);
   localparam logic [TAG_BITS-1:0] START_ROW = TAG_BITS'(TAG_NUM);
   localparam logic [TAG_BITS-1:0] ONE_T     = TAG_BITS'(1);
   localparam logic [LEN_BITS-1:0] ONE_L     = LEN_BITS'(1);
   localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_LEN);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_INIT   = 4'd1;
   localparam logic [3:0] S_RECUR  = 4'd2;
   localparam logic [3:0] S_UPDATE = 4'd3;
   localparam logic [3:0] S_WAIT   = 4'd4;
   localparam logic [3:0] S_FINAL  = 4'd5;
   localparam logic [3:0] S_BACK   = 4'd6;
   localparam logic [3:0] S_OUT    = 4'd7;
   localparam logic [3:0] S_DRAIN  = 4'd8;

   logic [3:0]           state, state_n;
   logic [LEN_BITS-1:0]  len, len_n;
   logic [WORD_BITS-1:0] w_reg, w_n;
   logic                 w_last, last_n;
   logic [TAG_BITS-1:0]  i_cnt, i_n;
   logic [TAG_BITS-1:0]  j_cnt, j_n;
   logic [LEN_BITS-1:0]  k_cnt, k_n;
   logic [P_SIZE-1:0]    best, best_n;
   logic [TAG_BITS-1:0]  best_i, best_i_n;
   logic                 done_n, error_n;
   logic                 tb_we;
   logic [LEN_BITS-1:0]  tb_wa;
   logic [TAG_BITS-1:0]  tb_wd;

   logic [P_SIZE-1:0]    cost     [TAG_NUM];
   logic [P_SIZE-1:0]    cost_new [TAG_NUM];
   logic [TAG_BITS-1:0]  bp       [MAX_LEN][TAG_NUM];
   logic [TAG_BITS-1:0]  tagbuf   [MAX_LEN];

   logic [P_SIZE-1:0]    cost_i, scan_val, min_val;
   logic [TAG_BITS-1:0]  min_idx, tag_fwd;
   logic                 take;

   // Saturating add: a (P_SIZE+1)-bit sum clamped to all-ones.
   function automatic logic [P_SIZE-1:0] sat_add(input logic [P_SIZE-1:0] a,
                                                 input logic [P_SIZE-1:0] b);
      logic [P_SIZE:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[P_SIZE] ? {P_SIZE{1'b1}} : s[P_SIZE-1:0];
   endfunction

   // Running strict-less minimum shared by RECUR (cost+trans) and FINAL (cost only).
   assign cost_i   = cost[TI_BITS'(i_cnt)];
   assign scan_val = (state == S_RECUR) ? sat_add(cost_i, trans_data) : cost_i;
   assign take     = (i_cnt == '0) || (scan_val < best);
   assign min_val  = take ? scan_val : best;
   assign min_idx  = take ? i_cnt : best_i;

   always_comb begin
      state_n  = state;
      len_n    = len;
      w_n      = w_reg;
      last_n   = w_last;
      i_n      = i_cnt;
      j_n      = j_cnt;
      k_n      = k_cnt;
      best_n   = best;
      best_i_n = best_i;
      done_n   = 1'b0;
      error_n  = 1'b0;
      tb_we    = 1'b0;
      tb_wa    = '0;
      tb_wd    = '0;
      case (state)
         S_IDLE: begin
            if (word_valid) begin
               state_n = S_INIT;
               len_n   = ONE_L;
               w_n     = word;
               last_n  = word_last;
               j_n     = '0;
            end
         end
         S_INIT: begin
            if (j_cnt == LAST_TAG) state_n = S_UPDATE;
            else                   j_n     = j_cnt + ONE_T;
         end
         S_WAIT: begin
            if (word_valid) begin
               if (len == MAX_LEN_L) begin
                  // Overflow: discard the word and skip to the end of the sentence.
                  error_n = 1'b1;
                  if (word_last) begin
                     state_n = S_IDLE;
                     len_n   = '0;
                  end else begin
                     state_n = S_DRAIN;
                  end
               end else begin
                  state_n = S_RECUR;
                  len_n   = len + ONE_L;
                  w_n     = word;
                  last_n  = word_last;
                  i_n     = '0;
                  j_n     = '0;
               end
            end
         end
         S_RECUR: begin
            best_n   = min_val;
            best_i_n = min_idx;
            if (i_cnt == LAST_TAG) begin
               i_n = '0;
               if (j_cnt == LAST_TAG) state_n = S_UPDATE;
               else                   j_n     = j_cnt + ONE_T;
            end else begin
               i_n = i_cnt + ONE_T;
            end
         end
         S_UPDATE: begin
            i_n     = '0;
            state_n = w_last ? S_FINAL : S_WAIT;
         end
         S_FINAL: begin
            best_n   = min_val;
            best_i_n = min_idx;
            if (i_cnt == LAST_TAG) begin
               tb_we   = 1'b1;
               tb_wa   = len - ONE_L;
               tb_wd   = min_idx;
               k_n     = len - ONE_L;
               state_n = (len == ONE_L) ? S_OUT : S_BACK;
            end else begin
               i_n = i_cnt + ONE_T;
            end
         end
         S_BACK: begin
            tb_we   = 1'b1;
            tb_wa   = k_cnt - ONE_L;
            tb_wd   = bp[IX_BITS'(k_cnt)][TI_BITS'(tagbuf[IX_BITS'(k_cnt)])];
            k_n     = k_cnt - ONE_L;
            state_n = (k_cnt == ONE_L) ? S_OUT : S_BACK;
         end
         S_OUT: begin
            if (tag_ready) begin
               if (k_cnt == len - ONE_L) begin
                  state_n = S_IDLE;
                  done_n  = 1'b1;
                  len_n   = '0;
               end else begin
                  k_n = k_cnt + ONE_L;
               end
            end
         end
         S_DRAIN: begin
            if (word_valid && word_last) begin
               state_n = S_IDLE;
               len_n   = '0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Forward a tagbuf write landing on the slot the output register is about to load.
   assign tag_fwd = (tb_we && (tb_wa == k_n)) ? tb_wd : tagbuf[IX_BITS'(k_n)];

   // State, control and output registers; outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         len        <= '0;
         w_reg      <= '0;
         w_last     <= 1'b0;
         i_cnt      <= '0;
         j_cnt      <= '0;
         k_cnt      <= '0;
         best       <= '0;
         best_i     <= '0;
         word_ready <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         tag_valid  <= 1'b0;
         tag        <= '0;
         tag_idx    <= '0;
         tag_last   <= 1'b0;
         trans_from <= '0;
         trans_to   <= '0;
         emiss_word <= '0;
         emiss_tag  <= '0;
      end else begin
         state      <= state_n;
         len        <= len_n;
         w_reg      <= w_n;
         w_last     <= last_n;
         i_cnt      <= i_n;
         j_cnt      <= j_n;
         k_cnt      <= k_n;
         best       <= best_n;
         best_i     <= best_i_n;
         word_ready <= (state_n == S_IDLE) || (state_n == S_WAIT) || (state_n == S_DRAIN);
         busy       <= (state_n != S_IDLE);
         done       <= done_n;
         error      <= error_n;
         tag_valid  <= (state_n == S_OUT);
         tag        <= (state_n == S_OUT) ? tag_fwd : '0;
         tag_idx    <= (state_n == S_OUT) ? k_n : '0;
         tag_last   <= (state_n == S_OUT) && (k_n == len_n - ONE_L);
         trans_from <= (state_n == S_INIT)  ? START_ROW :
                       (state_n == S_RECUR) ? i_n : '0;
         trans_to   <= ((state_n == S_INIT) || (state_n == S_RECUR)) ? j_n : '0;
         emiss_word <= ((state_n == S_INIT) || (state_n == S_RECUR)) ? w_n : '0;
         emiss_tag  <= ((state_n == S_INIT) || (state_n == S_RECUR)) ? j_n : '0;
      end
   end

   // Cost vectors, backpointers and the decoded tag buffer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == S_INIT)
            cost_new[TI_BITS'(j_cnt)] <= sat_add(trans_data, emiss_data);
         if ((state == S_RECUR) && (i_cnt == LAST_TAG)) begin
            cost_new[TI_BITS'(j_cnt)]                   <= sat_add(min_val, emiss_data);
            bp[IX_BITS'(len - ONE_L)][TI_BITS'(j_cnt)] <= min_idx;
         end
         if (state == S_UPDATE)
            cost <= cost_new;
         if (tb_we)
            tagbuf[IX_BITS'(tb_wa)] <= tb_wd;
      end
   end

endmodule

// File: tb/tb_viterbi_stream_tagger.sv
// Directed bench: a 2-tag instance with hand-worked tables and a default-parameter
// instance whose emission table makes the best tag of word w equal to w mod 11.
module tb_viterbi_stream_tagger;

   logic clk;
   logic reset;
   bit   sel;
   logic wv, wl, tr;
   logic [3:0] wd;
   int   mode_a;
   int   vectors = 0;
   int   miscompares = 0;
   logic [3:0] exp_tags[$];

   logic        word_ready_a, tag_valid_a, tag_last_a, busy_a, done_a, error_a;
   logic [3:0]  trans_from_a, trans_to_a, emiss_word_a, emiss_tag_a, tag_a;
   logic [4:0]  tag_idx_a;
   logic [31:0] trans_data_a, emiss_data_a;

   logic        word_ready_b, tag_valid_b, tag_last_b, busy_b, done_b, error_b;
   logic [3:0]  trans_from_b, trans_to_b, emiss_word_b, emiss_tag_b, tag_b;
   logic [4:0]  tag_idx_b;
   logic [31:0] trans_data_b, emiss_data_b;

   logic        m_word_ready, m_tag_valid, m_tag_last, m_busy, m_done, m_error;
   logic [3:0]  m_tag;
   logic [4:0]  m_tag_idx;
   logic [15:0] m_addr;

   int err_cnt_b = 0;
   int tv_cnt_b  = 0;

   function automatic logic [31:0] ta(input logic [3:0] f, input logic [3:0] t, input int mode);
      if (mode == 1) return 32'hFFFF_FFFF;
      case (f)
         4'd2:    return (t == 4'd0) ? ((mode == 2) ? 32'hFFFF_FFFF : 32'd1) : 32'd5;
         4'd0:    return (t == 4'd0) ? 32'd1 : 32'd4;
         4'd1:    return (t == 4'd0) ? 32'd3 : 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ea(input logic [3:0] w, input logic [3:0] t, input int mode);
      if (mode == 1) return 32'hFFFF_FFFF;
      if (mode == 2) return 32'd1;
      if (w == 4'd7) return (t == 4'd0) ? 32'd2 : 32'd1;
      if (w == 4'd9) return (t == 4'd0) ? 32'd6 : 32'd0;
      return 32'd0;
   endfunction

   assign trans_data_a = ta(trans_from_a, trans_to_a, mode_a);
   assign emiss_data_a = ea(emiss_word_a, emiss_tag_a, mode_a);
   assign trans_data_b = 32'd0;
   assign emiss_data_b = ((32'(emiss_word_b) % 32'd11) == 32'(emiss_tag_b)) ? 32'd0 : 32'd100;

   viterbi_stream_tagger #(.TAG_NUM(2)) dut_a (
      .clk(clk), .reset(reset),
      .word_valid(wv & ~sel), .word_ready(word_ready_a), .word(wd), .word_last(wl),
      .trans_from(trans_from_a), .trans_to(trans_to_a), .trans_data(trans_data_a),
      .emiss_word(emiss_word_a), .emiss_tag(emiss_tag_a), .emiss_data(emiss_data_a),
      .tag_valid(tag_valid_a), .tag_ready(tr), .tag(tag_a), .tag_idx(tag_idx_a),
      .tag_last(tag_last_a), .busy(busy_a), .done(done_a), .error(error_a)
   );

   viterbi_stream_tagger dut_b (
      .clk(clk), .reset(reset),
      .word_valid(wv & sel), .word_ready(word_ready_b), .word(wd), .word_last(wl),
      .trans_from(trans_from_b), .trans_to(trans_to_b), .trans_data(trans_data_b),
      .emiss_word(emiss_word_b), .emiss_tag(emiss_tag_b), .emiss_data(emiss_data_b),
      .tag_valid(tag_valid_b), .tag_ready(tr), .tag(tag_b), .tag_idx(tag_idx_b),
      .tag_last(tag_last_b), .busy(busy_b), .done(done_b), .error(error_b)
   );

   assign m_word_ready = sel ? word_ready_b : word_ready_a;
   assign m_tag_valid  = sel ? tag_valid_b  : tag_valid_a;
   assign m_tag_last   = sel ? tag_last_b   : tag_last_a;
   assign m_busy       = sel ? busy_b       : busy_a;
   assign m_done       = sel ? done_b       : done_a;
   assign m_error      = sel ? error_b      : error_a;
   assign m_tag        = sel ? tag_b        : tag_a;
   assign m_tag_idx    = sel ? tag_idx_b    : tag_idx_a;
   assign m_addr       = sel ? {trans_from_b, trans_to_b, emiss_word_b, emiss_tag_b}
                             : {trans_from_a, trans_to_a, emiss_word_a, emiss_tag_a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (error_b)     err_cnt_b++;
      if (tag_valid_b) tv_cnt_b++;
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] w, input bit last);
      int n;
      bit hs;
      n = 0;
      wv = 1'b1; wd = w; wl = last;
      do begin
         hs = m_word_ready;
         @(posedge clk); #1;
         n++;
      end while (!hs && n < 20000);
      wv = 1'b0; wl = 1'b0;
      chk("word_handshake", 64'(hs), 64'd1);
   endtask

   task automatic collect(input int stall_at);
      int n, k, guard;
      n = exp_tags.size(); k = 0; guard = 0;
      while (k < n && guard < 20000) begin
         if (!m_tag_valid) begin
            @(posedge clk); #1;
            guard++;
         end else begin
            if (k == 0) chk("addr_zero_in_out", 64'(m_addr), 64'd0);
            if (k == stall_at) begin
               tr = 1'b0;
               repeat (5) begin
                  @(posedge clk); #1;
                  chk("stall_valid", 64'(m_tag_valid), 64'd1);
                  chk("stall_tag", 64'(m_tag), 64'(exp_tags[k]));
                  chk("stall_idx", 64'(m_tag_idx), 64'(k));
               end
               tr = 1'b1;
            end
            chk("tag", 64'(m_tag), 64'(exp_tags[k]));
            chk("tag_idx", 64'(m_tag_idx), 64'(k));
            chk("tag_last", 64'(m_tag_last), 64'(k == n - 1));
            @(posedge clk); #1;
            k++;
         end
      end
      chk("tags_received", 64'(k), 64'(n));
      chk("done_pulse", 64'(m_done), 64'd1);
      chk("busy_after_done", 64'(m_busy), 64'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(m_done), 64'd0);
   endtask

   initial begin
      int n, eb, tvb;
      reset = 1'b1; wv = 1'b0; wl = 1'b0; wd = '0; tr = 1'b1; sel = 1'b0; mode_a = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = bit'(s);
         #0;
         chk("rst_word_ready", 64'(m_word_ready), 64'd1);
         chk("rst_tag_valid", 64'(m_tag_valid), 64'd0);
         chk("rst_tag", 64'({m_tag, m_tag_idx, m_tag_last}), 64'd0);
         chk("rst_flags", 64'({m_busy, m_done, m_error}), 64'd0);
         chk("rst_addr", 64'(m_addr), 64'd0);
      end
      sel = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      // Worked example: 7, 9(last) -> tags 0, 1 (tie at j=1 picks i=0).
      send(4'd7, 1'b0);
      chk("busy_after_first", 64'(m_busy), 64'd1);
      chk("not_ready_in_init", 64'(m_word_ready), 64'd0);
      send(4'd9, 1'b1);
      exp_tags = {4'd0, 4'd1};
      collect(-1);

      // Single word 9: initial costs [7,5] -> tag 1; latency counted from the handshake cycle.
      send(4'd9, 1'b1);
      n = 1;
      while (!m_tag_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("first_tag_latency", 64'(n), 64'd6);
      exp_tags = {4'd1};
      collect(-1);

      // Clamped start cost for tag 0 must stay at all-ones, so tag 1 (cost 6) wins.
      mode_a = 2;
      send(4'd0, 1'b1);
      exp_tags = {4'd1};
      collect(-1);

      // All-ones tables: every cost saturates and every tie resolves to tag 0.
      mode_a = 1;
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);
      send(4'd3, 1'b1);
      exp_tags = {4'd0, 4'd0, 4'd0};
      collect(-1);
      mode_a = 0;

      // Default instance: full 16-word sentence with a mid-stream stall.
      sel = 1'b1;
      @(posedge clk); #1;
      exp_tags.delete();
      for (int i = 0; i < 16; i++) begin
         send(4'(i), i == 15);
         exp_tags.push_back(4'(i % 11));
      end
      collect(7);

      // 17-word sentence: error after word 17, drain to word_last, no tags.
      eb = err_cnt_b; tvb = tv_cnt_b;
      for (int i = 0; i < 16; i++) send(4'(i), 1'b0);
      send(4'd9, 1'b0);
      chk("overflow_error", 64'(m_error), 64'd1);
      @(posedge clk); #1;
      chk("error_one_cycle", 64'(m_error), 64'd0);
      chk("drain_ready", 64'(m_word_ready), 64'd1);
      send(4'd1, 1'b0);
      send(4'd2, 1'b1);
      chk("drain_idle_busy", 64'(m_busy), 64'd0);
      @(posedge clk); #1;
      chk("error_pulses", 64'(err_cnt_b - eb), 64'd1);
      chk("no_tags_on_overflow", 64'(tv_cnt_b - tvb), 64'd0);

      send(4'd3, 1'b0);
      send(4'd12, 1'b1);
      exp_tags = {4'd3, 4'd1};
      collect(-1);

      // Reset during RECUR of word 3, then a fresh sentence.
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);
      send(4'd3, 1'b0);
      repeat (10) begin @(posedge clk); #1; end
      chk("busy_in_recur", 64'(m_busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset_ready", 64'(m_word_ready), 64'd1);
      chk("midreset_busy", 64'(m_busy), 64'd0);
      chk("midreset_tag_valid", 64'(m_tag_valid), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      send(4'd5, 1'b0);
      send(4'd6, 1'b1);
      exp_tags = {4'd5, 4'd6};
      collect(-1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
